fetch_queue: RTL and testbench

Instruction prefetch buffer between the instruction memory and the fetch-to-decode boundary of the pipelined RISC-V core. It replaces the single-cycle PC/instruction-memory path with a request/grant/response fetch port and a small in-order queue of fetched instructions. It presents one instruction per cycle to Decode, honours a Decode stall, and flushes on a taken branch/jump resolved in Execute (`PCSrcE`/`PCTargetE`).

---
 rtl/pipeline_pkg.sv | 17 +
 rtl/fetch_queue_if.sv | 31 +++
 rtl/fetch_queue_sync_fifo.sv | 59 +++++
 rtl/fetch_queue.sv | 104 ++++++++++
 tb/tb_fetch_queue.sv | 294 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the front end of the core.
//   XLEN      : architectural register / address width
//   NOP_INSTR : canonical NOP (addi x0, x0, 0) shown to Decode when nothing is valid
//   PC_STEP   : byte increment between sequential instructions
//   fetch_entry_t : one buffered fetch, {instr, pc}
package pipeline_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;
    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Instruction-memory fetch port: request/grant plus in-order response channel.
//   imem_req/imem_addr   : request from the fetch unit
//   imem_gnt             : memory accepts the request this cycle
//   imem_rvalid/rdata    : in-order response, at most one per cycle
// master = fetch unit, slave = instruction memory.
interface fetch_queue_if;
    import pipeline_pkg::*;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_gnt,
        input  imem_rvalid,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_gnt,
        output imem_rvalid,
        output imem_rdata
    );

endinterface

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO holding fetched {instr, pc} entries.
//   clk, rst   : clock, asynchronous active-low reset
//   push/data  : write an entry (ignored when full)
//   pop        : remove the head entry (ignored when empty)
//   flush      : empty the FIFO; wins over push/pop
//   full/empty : status
//   head       : current head entry, straight from storage (no bypass)
module sync_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] head
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wptr_q, rptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem_q[rptr_q];

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) wptr_q <= wptr_q + 1'b1;
            if (do_pop)  rptr_q <= rptr_q + 1'b1;
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; entries are only observed while counted.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem_q[wptr_q] <= push_data;
    end

endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer between instruction memory and Decode.
//   clk, rst          : clock, asynchronous active-low reset
//   PCSrcE/PCTargetE  : redirect from Execute; flushes the queue and in-flight fetches
//   StallD            : Decode holds the head entry
//   imem              : request/grant/response fetch port (master side)
//   ValidD/InstrD/PCD/PCPlus4D : head entry presented to Decode (NOP/0 when empty)
// A credit rule (occupancy + outstanding < DEPTH) guarantees every response has a slot.
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int unsigned     DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             PCSrcE,
    input  logic [XLEN-1:0]  PCTargetE,
    input  logic             StallD,
    fetch_queue_if.master    imem,
    output logic             ValidD,
    output logic [XLEN-1:0]  InstrD,
    output logic [XLEN-1:0]  PCD,
    output logic [XLEN-1:0]  PCPlus4D
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [XLEN-1:0] fetch_pc_q, resp_pc_q;
    logic [CW-1:0]   occ_q, outst_q, discard_q;
    logic [CW:0]     credit_used;
    logic            gnt, drop, push, pop;
    logic            fifo_full, fifo_empty;
    fetch_entry_t    head_entry, push_entry;

    assign credit_used   = {1'b0, occ_q} + {1'b0, outst_q};
    assign imem.imem_req  = rst && !PCSrcE && (credit_used < (CW + 1)'(DEPTH));
    assign imem.imem_addr = fetch_pc_q;

    assign gnt  = imem.imem_req && imem.imem_gnt;
    assign drop = imem.imem_rvalid && (discard_q != '0);
    // A response in the flush cycle is dropped along with everything older.
    assign push = imem.imem_rvalid && !drop && !PCSrcE && !fifo_full;
    assign pop  = ValidD && !StallD && !PCSrcE;

    assign push_entry.instr = imem.imem_rdata;
    assign push_entry.pc    = resp_pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_pc_q <= RESET_PC;
            resp_pc_q  <= RESET_PC;
            occ_q      <= '0;
            outst_q    <= '0;
            discard_q  <= '0;
        end else begin
            outst_q <= outst_q + CW'(gnt) - CW'(imem.imem_rvalid);
            if (PCSrcE) begin
                fetch_pc_q <= PCTargetE;
                resp_pc_q  <= PCTargetE;
                occ_q      <= '0;
                // Every request still in flight belongs to the old path.
                discard_q  <= outst_q - CW'(imem.imem_rvalid);
            end else begin
                if (gnt)  fetch_pc_q <= fetch_pc_q + PC_STEP;
                if (push) resp_pc_q  <= resp_pc_q + PC_STEP;
                if (drop) discard_q  <= discard_q - 1'b1;
                occ_q <= occ_q + CW'(push) - CW'(pop);
            end
        end
    end

    sync_fifo #(
        .WIDTH (2 * XLEN),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (PCSrcE),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (head_entry)
    );

    assign ValidD   = (occ_q != '0);
    assign InstrD   = ValidD ? head_entry.instr : NOP_INSTR;
    assign PCD      = ValidD ? head_entry.pc : '0;
    assign PCPlus4D = ValidD ? head_entry.pc + PC_STEP : '0;

    assert property (@(posedge clk) disable iff (!rst)
        imem.imem_rvalid && !drop && !PCSrcE |-> !fifo_full)
        else $error("fetch_queue: response arrived with queue full");

    assert property (@(posedge clk) disable iff (!rst)
        imem.imem_rvalid |-> (outst_q != '0))
        else $error("fetch_queue: response without outstanding request");

    assert property (@(posedge clk) disable iff (!rst)
        ValidD == !fifo_empty)
        else $error("fetch_queue: occupancy and storage disagree");

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
    import pipeline_pkg::*;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = 32'h0;
    logic        StallD = 1'b0;
    logic        ValidD, ValidD_hi;
    logic [31:0] InstrD, PCD, PCPlus4D, InstrD_hi, PCD_hi, PCPlus4D_hi;

    fetch_queue_if bus ();
    fetch_queue_if bus_hi ();

    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) u_dut (
        .clk       (clk),
        .rst       (rst),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .StallD    (StallD),
        .imem      (bus),
        .ValidD    (ValidD),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D)
    );

    // Second instance exercises PC wrap-around from a high reset PC.
    fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_dut_hi (
        .clk       (clk),
        .rst       (rst),
        .PCSrcE    (1'b0),
        .PCTargetE (32'h0),
        .StallD    (1'b0),
        .imem      (bus_hi),
        .ValidD    (ValidD_hi),
        .InstrD    (InstrD_hi),
        .PCD       (PCD_hi),
        .PCPlus4D  (PCPlus4D_hi)
    );

    typedef struct {
        logic [31:0] addr;
        int          gcycle;
        bit          stale;
    } pend_t;

    int          errors = 0;
    int          checks = 0;
    int          cyc = 0;
    int          gnt_pct = 100;
    int          rsp_pct = 100;
    logic [31:0] q_pc[$];      // entries Decode should see, in order
    pend_t       pend[$];      // granted requests awaiting response
    logic [31:0] m_fetch_pc = 32'h0;
    bit          last_valid;
    bit          hi_rv = 1'b0;
    logic [31:0] hi_addr = 32'h0;
    int          hi_n = 0;
    logic [31:0] hi_pc [3];
    logic [31:0] hi_pc4 [3];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return a | 32'h100;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive memory side, check outputs, advance the reference model.
    task automatic step();
        bit    resp;
        bit    exp_req;
        bit    granted;
        bit    pop;
        bit    hi_next_rv;
        logic [31:0] hi_next_addr;
        pend_t p;
        resp = 1'b0;
        if (pend.size() > 0 && pend[0].gcycle < cyc && $urandom_range(99) < rsp_pct)
            resp = 1'b1;
        bus.imem_rvalid = resp;
        if (resp) bus.imem_rdata = mem_data(pend[0].addr);
        else      bus.imem_rdata = 32'hDEAD_BEEF;
        bus.imem_gnt = ($urandom_range(99) < gnt_pct);
        bus_hi.imem_gnt    = 1'b1;
        bus_hi.imem_rvalid = hi_rv;
        bus_hi.imem_rdata  = mem_data(hi_addr);
        #1;
        exp_req = !PCSrcE && (q_pc.size() + pend.size() < DEPTH);
        chk("imem_req", {31'b0, bus.imem_req}, {31'b0, exp_req});
        if (exp_req) chk("imem_addr", bus.imem_addr, m_fetch_pc);
        chk("ValidD", {31'b0, ValidD}, {31'b0, q_pc.size() > 0});
        if (q_pc.size() > 0) begin
            chk("PCD", PCD, q_pc[0]);
            chk("InstrD", InstrD, mem_data(q_pc[0]));
            chk("PCPlus4D", PCPlus4D, q_pc[0] + 32'd4);
        end else begin
            chk("InstrD_nop", InstrD, 32'h0000_0013);
            chk("PCD_zero", PCD, 32'h0);
            chk("PCPlus4D_zero", PCPlus4D, 32'h0);
        end
        last_valid = ValidD;
        if (ValidD_hi && hi_n < 3) begin
            hi_pc[hi_n]  = PCD_hi;
            hi_pc4[hi_n] = PCPlus4D_hi;
            hi_n++;
        end
        granted      = exp_req && bus.imem_gnt;
        pop          = (q_pc.size() > 0) && !StallD && !PCSrcE;
        hi_next_rv   = bus_hi.imem_req;
        hi_next_addr = bus_hi.imem_addr;
        @(posedge clk);
        if (pop) void'(q_pc.pop_front());
        if (resp) begin
            p = pend.pop_front();
            if (!PCSrcE && !p.stale) q_pc.push_back(p.addr);
        end
        if (PCSrcE) begin
            q_pc.delete();
            foreach (pend[i]) pend[i].stale = 1'b1;
            m_fetch_pc = PCTargetE;
        end
        if (granted) begin
            p.addr   = m_fetch_pc;
            p.gcycle = cyc;
            p.stale  = 1'b0;
            pend.push_back(p);
            m_fetch_pc = m_fetch_pc + 32'd4;
        end
        hi_rv   = hi_next_rv;
        hi_addr = hi_next_addr;
        cyc++;
        @(negedge clk);
    endtask

    // Assert reset mid-cycle and check outputs before any clock edge.
    task automatic do_reset();
        #2;
        rst = 1'b0;
        #1;
        chk("rst_ValidD", {31'b0, ValidD}, 32'h0);
        chk("rst_InstrD", InstrD, 32'h0000_0013);
        chk("rst_PCD", PCD, 32'h0);
        chk("rst_PCPlus4D", PCPlus4D, 32'h0);
        chk("rst_imem_req", {31'b0, bus.imem_req}, 32'h0);
        chk("rst_imem_addr", bus.imem_addr, 32'h0);
        chk("rst_hi_imem_addr", bus_hi.imem_addr, 32'hFFFF_FFF8);
        q_pc.delete();
        pend.delete();
        m_fetch_pc = 32'h0;
        hi_rv = 1'b0;
        hi_n = 0;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;
        bus_hi.imem_gnt = 1'b0;
        bus_hi.imem_rvalid = 1'b0;
        bus_hi.imem_rdata = 32'h0;
        PCSrcE = 1'b0;
        StallD = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    task automatic first_valid(input string tag, input logic [31:0] exp_pc);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ValidD) found = 1'b1;
            else step();
        end
        chk({tag, "_found"}, {31'b0, found}, 32'h1);
        if (found) begin
            chk({tag, "_pc"}, PCD, exp_pc);
            chk({tag, "_pc4"}, PCPlus4D, exp_pc + 32'd4);
        end
    endtask

    initial begin
        int first_v;
        bus.imem_gnt = 1'b0;
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata = 32'h0;
        bus_hi.imem_gnt = 1'b0;
        bus_hi.imem_rvalid = 1'b0;
        bus_hi.imem_rdata = 32'h0;

        // Reset, then zero-latency memory: head valid two cycles after release.
        do_reset();
        rst = 1'b1;
        gnt_pct = 100;
        rsp_pct = 100;
        first_v = -1;
        for (int i = 0; i < 12; i++) begin
            step();
            if (last_valid && first_v < 0) first_v = i;
        end
        chk("first_valid_latency", first_v, 32'd2);
        chk("hi_count", hi_n, 32'd3);
        chk("hi_pc0", hi_pc[0], 32'hFFFF_FFF8);
        chk("hi_pc1", hi_pc[1], 32'hFFFF_FFFC);
        chk("hi_pc2", hi_pc[2], 32'h0000_0000);
        chk("hi_pc4_1", hi_pc4[1], 32'h0000_0000);

        // Stall from reset: queue fills with 0..12 and requests stop.
        do_reset();
        rst = 1'b1;
        StallD = 1'b1;
        for (int i = 0; i < 10; i++) step();
        chk("stall_req_stopped", {31'b0, bus.imem_req}, 32'h0);
        chk("stall_head_pc", PCD, 32'h0);
        StallD = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc", PCD, 32'(i * 4));
            step();
        end
        for (int i = 0; i < 6; i++) step();

        // Three in flight, flush to 0x40 while one response arrives.
        do_reset();
        rst = 1'b1;
        StallD = 1'b1;
        rsp_pct = 0;
        for (int i = 0; i < 3; i++) step();
        gnt_pct = 0;
        rsp_pct = 100;
        PCSrcE = 1'b1;
        PCTargetE = 32'h40;
        step();
        PCSrcE = 1'b0;
        StallD = 1'b0;
        gnt_pct = 100;
        chk("flush_valid_drop", {31'b0, ValidD}, 32'h0);
        first_valid("flush40", 32'h40);
        for (int i = 0; i < 6; i++) step();

        // Back-to-back flushes with random memory timing.
        gnt_pct = 60;
        rsp_pct = 60;
        for (int i = 0; i < 5; i++) step();
        PCSrcE = 1'b1;
        PCTargetE = 32'h80;
        step();
        PCTargetE = 32'h200;
        step();
        PCSrcE = 1'b0;
        first_valid("flush200", 32'h200);
        for (int i = 0; i < 40; i++) begin
            StallD = ($urandom_range(99) < 25);
            step();
        end

        // Random traffic with occasional redirects.
        for (int i = 0; i < 300; i++) begin
            StallD = ($urandom_range(99) < 30);
            gnt_pct = 40 + int'($urandom_range(60));
            rsp_pct = 40 + int'($urandom_range(60));
            PCSrcE = ($urandom_range(99) < 5);
            PCTargetE = 32'h1000 + {20'h0, 10'($urandom_range(1023)), 2'b00};
            step();
        end
        PCSrcE = 1'b0;
        StallD = 1'b0;

        // Reset with two queued and two outstanding; restart cleanly at RESET_PC.
        do_reset();
        rst = 1'b1;
        StallD = 1'b1;
        gnt_pct = 100;
        rsp_pct = 100;
        for (int i = 0; i < 3; i++) step();
        rsp_pct = 0;
        step();
        do_reset();
        rst = 1'b1;
        rsp_pct = 100;
        first_valid("after_reset", 32'h0);
        for (int i = 0; i < 10; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
